mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-copy initiator for the single-port synchronous RAM: it drives the RAM's enable, read, write, address and write-data lines and captures the RAM's registered read data. On a `start` pulse it copies `len` words from `src_adr` upward to `dst_adr` upward, one word at a time. Its RAM-side outputs share the RAM port with the processor through the existing datapath mux, and `busy` grants it ownership.

## Interface
- `WIDTH`, 16, data word width; matches the RAM.
- `RAM_ADDR_BITS`, 16, RAM address width; also the width of `len`.
- `clk`  in  1  system clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  stops the copy at the next edge.
- `src_adr`, `dst_adr`  in  RAM_ADDR_BITS  first source and destination addresses; sampled with `start`.
- `len`  in  RAM_ADDR_BITS  word count; sampled with `start`.
- `busy`  out  1  high while the engine owns the RAM port.
- `done`  out  1  one-cycle pulse when a copy completes.
- `en`, `memread`, `memwrite`  out  1  RAM controls.
- `adr`  out  RAM_ADDR_BITS  RAM address.
- `writedata`  out  WIDTH  RAM write data.
- `memdata`  in  WIDTH  RAM read data, valid the cycle after a read.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- IDLE, `start`=1, `len`≠0: latch `src_adr`, `dst_adr`, `len`; clear the index; go to READ.
- IDLE, `start`=1, `len`=0: go to DONE; no RAM access is made.
- READ: `en`=1, `memread`=1, `adr`=src+idx; next state WRITE.
- WRITE: `en`=1, `memwrite`=1, `adr`=dst+idx, `writedata`=`memdata`. Then increment idx. If idx+1 equals `len`, go to DONE, else go to READ.
- DONE: `done`=1 for one cycle; `busy`=0; next state IDLE.
- `busy` = 1 in READ and WRITE only.
- `start` outside IDLE is ignored.
- `abort`=1 in READ or WRITE: go to IDLE next edge with no `done`. The access in the current cycle still completes.
- Address arithmetic is modulo 2^RAM_ADDR_BITS, so `adr` wraps from all-ones to 0.
- The index counter is RAM_ADDR_BITS wide. `len`=2^RAM_ADDR_BITS−1 is the maximum copy.
- Copy order is strictly ascending. Overlap with dst in (src, src+len) propagates already-written words; this is the defined behaviour, not an error.
- RAM controls are decoded from state only (Moore), so they are glitch-free on a registered state.

## Timing
- Cycle-level sequence:
  - `start` is sampled at edge k.
  - The first READ cycle is k→k+1.
  - Each word takes 2 cycles.
  - `done` is high in cycle k+2·len+1.
  - IDLE returns one cycle later.
- `len`=0: `done` is high in cycle k+1.
- RAM read latency is 1 cycle. `memdata` is sampled combinationally in WRITE, right after the READ edge.
- Async reset mid-copy: controls drop to 0 immediately. The in-flight write is not guaranteed; earlier words are already committed.
- `start` and `abort` in the same IDLE cycle: `start` wins and `abort` is ignored.

## Configuration
- `MEM_COPY_FILL_EN` defined:
  - Adds input `fill` (1) and input `fill_data` (WIDTH).
  - If `fill`=1 at `start`, the engine skips READ and enters WRITE.
  - It writes the latched `fill_data` to dst+idx every cycle, so 1 cycle per word.
  - `done` is high in cycle k+len+1.
- `MEM_COPY_FILL_EN` undefined: the `fill` and `fill_data` ports are absent; every request is a copy.

## Structure
- Package `mem_copy_pkg` holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - the state-width constant.
- No sub-module. Counter, address adders and the FSM live in `mem_copy_engine`.

## Test plan
- Copy, src=0x0010, dst=0x0100, len=4, RAM[0x10..0x13]=A,B,C,D → RAM[0x100..0x103]=A,B,C,D; `done` 9 cycles after `start`; `busy` high 8 cycles.
- len=0 → `done` the next cycle; `en`, `memread`, `memwrite` never asserted.
- Wrap, src=0xFFFE, len=3 → reads 0xFFFE, 0xFFFF, 0x0000; writes to dst, dst+1, dst+2 in order.
- `abort` in the second WRITE of a len=5 copy → 2 words written; no `done`; IDLE next cycle; a new `start` works.
- Reset asserted mid-copy → all outputs 0 asynchronously; after release, a len=1 copy completes normally.
- With `MEM_COPY_FILL_EN`, fill=1, fill_data=0xBEEF, len=3, dst=0x20 → RAM[0x20..0x22]=0xBEEF; no reads; `done` 4 cycles after `start`.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types for the block-copy engine: FSM state encoding and its width.
package mem_copy_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// RAM-side port of the copy engine: controls, address, write data and registered read data.
interface mem_copy_engine_if #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 16
);

   logic                 en;
   logic                 memread;
   logic                 memwrite;
   logic [ADDR_BITS-1:0] adr;
   logic [WIDTH-1:0]     writedata;
   logic [WIDTH-1:0]     memdata;

   modport master (
      output en, memread, memwrite, adr, writedata,
      input  memdata
   );

   modport slave (
      input  en, memread, memwrite, adr, writedata,
      output memdata
   );

endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the single-port RAM; copies len words src->dst in ascending order.
// Optional constant-fill mode is enabled with `define MEM_COPY_FILL_EN.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int RAM_ADDR_BITS = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [RAM_ADDR_BITS-1:0] src_adr,
   input  logic [RAM_ADDR_BITS-1:0] dst_adr,
   input  logic [RAM_ADDR_BITS-1:0] len,
`ifdef MEM_COPY_FILL_EN
   input  logic                     fill,
   input  logic [WIDTH-1:0]         fill_data,
`endif
   output logic                     busy,
   output logic                     done,
   mem_copy_engine_if.master        ram
);

   state_t                   state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] src_q, dst_q, len_q, idx_q;
   logic [RAM_ADDR_BITS-1:0] idx_nxt;
   logic                     load, inc;
   logic                     fill_mode_q;
   logic [WIDTH-1:0]         fill_data_q;
   logic                     fill_req;

   assign idx_nxt = idx_q + 1'b1;

`ifdef MEM_COPY_FILL_EN
   assign fill_req = fill;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_mode_q <= 1'b0;
         fill_data_q <= '0;
      end else if (load) begin
         fill_mode_q <= fill;
         fill_data_q <= fill_data;
      end
   end
`else
   assign fill_req    = 1'b0;
   assign fill_mode_q = 1'b0;
   assign fill_data_q = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // abort is deliberately not looked at here: start wins
            if (start) begin
               if (len == '0) begin
                  state_d = DONE;
               end else begin
                  load    = 1'b1;
                  state_d = fill_req ? WRITE : READ;
               end
            end
         end
         READ: begin
            state_d = abort ? IDLE : WRITE;
         end
         WRITE: begin
            inc = 1'b1;
            if (abort)                 state_d = IDLE;
            else if (idx_nxt == len_q) state_d = DONE;
            else                       state_d = fill_mode_q ? WRITE : READ;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else if (load) begin
         src_q <= src_adr;
         dst_q <= dst_adr;
         len_q <= len;
         idx_q <= '0;
      end else if (inc) begin
         idx_q <= idx_nxt;
      end
   end

   // RAM controls depend on the registered state only, so they never glitch
   always_comb begin
      ram.en        = 1'b0;
      ram.memread   = 1'b0;
      ram.memwrite  = 1'b0;
      ram.adr       = '0;
      ram.writedata = '0;
      busy          = 1'b0;
      done          = 1'b0;
      unique case (state_q)
         READ: begin
            ram.en      = 1'b1;
            ram.memread = 1'b1;
            ram.adr     = src_q + idx_q;
            busy        = 1'b1;
         end
         WRITE: begin
            ram.en        = 1'b1;
            ram.memwrite  = 1'b1;
            ram.adr       = dst_q + idx_q;
            ram.writedata = fill_mode_q ? fill_data_q : ram.memdata;
            busy          = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural 1-cycle-latency RAM.
// Define MEM_COPY_FILL_EN to also exercise the fill mode.
module tb_mem_copy_engine;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [15:0] src_adr, dst_adr, len;
   logic        busy, done;
`ifdef MEM_COPY_FILL_EN
   logic        fill;
   logic [15:0] fill_data;
`endif

   int checks;
   int errors;

   mem_copy_engine_if #(.WIDTH(16), .ADDR_BITS(16)) ram ();

   mem_copy_engine #(.WIDTH(16), .RAM_ADDR_BITS(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .src_adr   (src_adr),
      .dst_adr   (dst_adr),
      .len       (len),
`ifdef MEM_COPY_FILL_EN
      .fill      (fill),
      .fill_data (fill_data),
`endif
      .busy      (busy),
      .done      (done),
      .ram       (ram)
   );

   // behavioural RAM with access logs
   logic [15:0] mem [0:65535];
   logic [15:0] rd_q;
   logic        poke_en;
   logic [15:0] poke_adr, poke_dat;
   logic [15:0] wr_adr[$];
   logic [15:0] wr_dat[$];
   logic [15:0] rd_adr[$];

   always @(posedge clk) begin
      if (poke_en) begin
         mem[poke_adr] <= poke_dat;
      end else if (ram.en && ram.memwrite) begin
         mem[ram.adr] <= ram.writedata;
         wr_adr.push_back(ram.adr);
         wr_dat.push_back(ram.writedata);
      end
      if (ram.en && ram.memread) begin
         rd_q <= mem[ram.adr];
         rd_adr.push_back(ram.adr);
      end
   end
   assign ram.memdata = rd_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic poke(input logic [15:0] a, input logic [15:0] d);
      poke_en  = 1'b1;
      poke_adr = a;
      poke_dat = d;
      @(posedge clk); #1;
      poke_en  = 1'b0;
   endtask

   // Issues one request and reports on which sample (1 = first cycle after the start edge) done appeared
   task automatic run_req(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input logic ab, output int done_at, output int busy_cnt,
                          output logic done_next, output logic busy_next);
      src_adr = s;
      dst_adr = d;
      len     = l;
      start   = 1'b1;
      abort   = ab;
      @(posedge clk); #1;
      start   = 1'b0;
      abort   = 1'b0;
      done_at  = -1;
      busy_cnt = 0;
      for (int n = 1; n <= 300; n++) begin
         if (done) begin
            done_at = n;
            break;
         end
         if (busy) busy_cnt++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      done_next = done;
      busy_next = busy;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #2;
      checks++;
      if ({busy, done, ram.en, ram.memread, ram.memwrite} !== 5'b0 ||
          ram.adr !== 16'h0 || ram.writedata !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: ctl=%b adr=%h wd=%h, required all zero",
                  {busy, done, ram.en, ram.memread, ram.memwrite}, ram.adr, ram.writedata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_copy;
      int da, bc, base;
      logic dn, bn;
      logic [15:0] exp_d [4];
      exp_d = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
      for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), exp_d[i]);
      base = wr_adr.size();
      run_req(16'h0010, 16'h0100, 16'd4, 1'b0, da, bc, dn, bn);
      checks++;
      if (da !== 9) begin errors++; $display("FAIL copy_done_time: got %0d, required 9", da); end
      checks++;
      if (bc !== 8) begin errors++; $display("FAIL copy_busy_cycles: got %0d, required 8", bc); end
      checks++;
      if (dn !== 1'b0 || bn !== 1'b0) begin
         errors++; $display("FAIL copy_after_done: done=%b busy=%b, required 0 0", dn, bn);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[16'h0100 + 16'(i)] !== exp_d[i]) begin
            errors++;
            $display("FAIL copy_data[%0d]: got %h, required %h", i, mem[16'h0100 + 16'(i)], exp_d[i]);
         end
      end
      checks++;
      if (wr_adr.size() - base !== 4) begin
         errors++; $display("FAIL copy_write_count: got %0d, required 4", wr_adr.size() - base);
      end
   endtask

   task automatic test_len_zero;
      int da, bc, wb, rb;
      logic dn, bn;
      wb = wr_adr.size();
      rb = rd_adr.size();
      run_req(16'h0010, 16'h0500, 16'd0, 1'b0, da, bc, dn, bn);
      checks++;
      if (da !== 1) begin errors++; $display("FAIL len0_done_time: got %0d, required 1", da); end
      checks++;
      if (wr_adr.size() - wb !== 0 || rd_adr.size() - rb !== 0 || bc !== 0) begin
         errors++;
         $display("FAIL len0_no_access: writes=%0d reads=%0d busy=%0d, required 0 0 0",
                  wr_adr.size() - wb, rd_adr.size() - rb, bc);
      end
   endtask

   task automatic test_wrap;
      int da, bc, wb, rb;
      logic dn, bn;
      logic [15:0] ra [3];
      logic [15:0] dv [3];
      ra = '{16'hFFFE, 16'hFFFF, 16'h0000};
      dv = '{16'h1111, 16'h2222, 16'h3333};
      for (int i = 0; i < 3; i++) poke(ra[i], dv[i]);
      wb = wr_adr.size();
      rb = rd_adr.size();
      run_req(16'hFFFE, 16'h0200, 16'd3, 1'b0, da, bc, dn, bn);
      checks++;
      if (da !== 7) begin errors++; $display("FAIL wrap_done_time: got %0d, required 7", da); end
      checks++;
      if (rd_adr.size() - rb !== 3 || wr_adr.size() - wb !== 3) begin
         errors++;
         $display("FAIL wrap_counts: reads=%0d writes=%0d, required 3 3",
                  rd_adr.size() - rb, wr_adr.size() - wb);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_adr[rb + i] !== ra[i] || wr_adr[wb + i] !== 16'h0200 + 16'(i) ||
                wr_dat[wb + i] !== dv[i]) begin
               errors++;
               $display("FAIL wrap_access[%0d]: rd=%h wr=%h data=%h, required %h %h %h", i,
                        rd_adr[rb + i], wr_adr[wb + i], wr_dat[wb + i], ra[i], 16'h0200 + 16'(i), dv[i]);
            end
         end
      end
   endtask

   task automatic test_abort;
      int wb, da, bc;
      logic dn, bn;
      logic seen_done;
      poke(16'h0014, 16'hE4E4);
      wb = wr_adr.size();
      src_adr = 16'h0010;
      dst_adr = 16'h0400;
      len     = 16'd5;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen_done = 1'b0;
      // samples: READ, WRITE, READ, then the second WRITE
      for (int n = 1; n < 4; n++) begin
         seen_done |= done;
         @(posedge clk); #1;
      end
      checks++;
      if (!(ram.en && ram.memwrite)) begin
         errors++; $display("FAIL abort_in_write: en=%b memwrite=%b, required 1 1", ram.en, ram.memwrite);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      seen_done |= done;
      checks++;
      if (busy !== 1'b0 || ram.en !== 1'b0) begin
         errors++; $display("FAIL abort_idle: busy=%b en=%b, required 0 0", busy, ram.en);
      end
      @(posedge clk); #1;
      seen_done |= done;
      checks++;
      if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: done seen=%b, required 0", seen_done); end
      checks++;
      if (wr_adr.size() - wb !== 2) begin
         errors++; $display("FAIL abort_write_count: got %0d, required 2", wr_adr.size() - wb);
      end
      checks++;
      if (mem[16'h0400] !== 16'hA0A0 || mem[16'h0401] !== 16'hB1B1) begin
         errors++; $display("FAIL abort_data: got %h %h, required a0a0 b1b1", mem[16'h0400], mem[16'h0401]);
      end
      run_req(16'h0013, 16'h0410, 16'd2, 1'b0, da, bc, dn, bn);
      checks++;
      if (da !== 5 || mem[16'h0410] !== 16'hD3D3 || mem[16'h0411] !== 16'hE4E4) begin
         errors++;
         $display("FAIL abort_restart: done_at=%0d data=%h %h, required 5 d3d3 e4e4",
                  da, mem[16'h0410], mem[16'h0411]);
      end
   endtask

   task automatic test_reset_mid_copy;
      int da, bc;
      logic dn, bn;
      src_adr = 16'h0010;
      dst_adr = 16'h0300;
      len     = 16'd4;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, ram.en, ram.memread, ram.memwrite} !== 5'b0 ||
          ram.adr !== 16'h0 || ram.writedata !== 16'h0) begin
         errors++;
         $display("FAIL midreset_outputs: ctl=%b adr=%h wd=%h, required all zero",
                  {busy, done, ram.en, ram.memread, ram.memwrite}, ram.adr, ram.writedata);
      end
      checks++;
      if (mem[16'h0300] !== 16'hA0A0) begin
         errors++; $display("FAIL midreset_committed: got %h, required a0a0", mem[16'h0300]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_req(16'h0013, 16'h0310, 16'd1, 1'b0, da, bc, dn, bn);
      checks++;
      if (da !== 3 || bc !== 2 || mem[16'h0310] !== 16'hD3D3) begin
         errors++;
         $display("FAIL midreset_recover: done_at=%0d busy=%0d data=%h, required 3 2 d3d3",
                  da, bc, mem[16'h0310]);
      end
   endtask

   // start together with abort in IDLE, then a stray start while busy
   task automatic test_back_to_back;
      int da, bc, wb;
      logic dn, bn;
      wb = wr_adr.size();
      src_adr = 16'h0010;
      dst_adr = 16'h0600;
      len     = 16'd2;
      start   = 1'b1;
      abort   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      abort   = 1'b0;
      @(posedge clk); #1;
      src_adr = 16'h0012;
      dst_adr = 16'h0700;
      len     = 16'd1;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      da = -1;
      for (int n = 3; n <= 50; n++) begin
         if (done) begin da = n; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (da !== 5) begin errors++; $display("FAIL b2b_done_time: got %0d, required 5", da); end
      checks++;
      if (mem[16'h0600] !== 16'hA0A0 || mem[16'h0601] !== 16'hB1B1 || wr_adr.size() - wb !== 2) begin
         errors++;
         $display("FAIL b2b_data: got %h %h writes=%0d, required a0a0 b1b1 2",
                  mem[16'h0600], mem[16'h0601], wr_adr.size() - wb);
      end
      @(posedge clk); #1;
      run_req(16'h0011, 16'h0620, 16'd1, 1'b0, da, bc, dn, bn);
      checks++;
      if (da !== 3 || mem[16'h0620] !== 16'hB1B1) begin
         errors++; $display("FAIL b2b_next: done_at=%0d data=%h, required 3 b1b1", da, mem[16'h0620]);
      end
   endtask

`ifdef MEM_COPY_FILL_EN
   task automatic test_fill;
      int da, bc, wb, rb;
      logic dn, bn;
      wb = wr_adr.size();
      rb = rd_adr.size();
      fill      = 1'b1;
      fill_data = 16'hBEEF;
      run_req(16'h0010, 16'h0020, 16'd3, 1'b0, da, bc, dn, bn);
      fill      = 1'b0;
      checks++;
      if (da !== 4 || bc !== 3) begin
         errors++; $display("FAIL fill_timing: done_at=%0d busy=%0d, required 4 3", da, bc);
      end
      checks++;
      if (rd_adr.size() - rb !== 0 || wr_adr.size() - wb !== 3) begin
         errors++;
         $display("FAIL fill_counts: reads=%0d writes=%0d, required 0 3",
                  rd_adr.size() - rb, wr_adr.size() - wb);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[16'h0020 + 16'(i)] !== 16'hBEEF) begin
            errors++; $display("FAIL fill_data[%0d]: got %h, required beef", i, mem[16'h0020 + 16'(i)]);
         end
      end
   endtask
`endif

   initial begin
      checks   = 0;
      errors   = 0;
      start    = 1'b0;
      abort    = 1'b0;
      src_adr  = '0;
      dst_adr  = '0;
      len      = '0;
      poke_en  = 1'b0;
      poke_adr = '0;
      poke_dat = '0;
`ifdef MEM_COPY_FILL_EN
      fill      = 1'b0;
      fill_data = '0;
`endif
      test_reset();
      test_copy();
      test_len_zero();
      test_wrap();
      test_abort();
      test_reset_mid_copy();
      test_back_to_back();
`ifdef MEM_COPY_FILL_EN
      test_fill();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
